rf_access_ctrl: RTL and testbench



---
 rtl/rf_access_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rf_access_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_ctrl.sv
// rtl/rf_access_ctrl.sv - initiator-side controller for the 32x32 register file
module rf_access_ctrl #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 32,
    parameter int ADDRESSWIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESSWIDTH-1:0] req_addr,
    input  logic [ADDRESSWIDTH:0]   req_len,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [ADDRESSWIDTH-1:0] rsp_addr,
    output logic                    rsp_last,
    output logic                    rf_we,
    output logic [ADDRESSWIDTH-1:0] rf_dest,
    output logic [WIDTH-1:0]        rf_wdata,
    output logic [ADDRESSWIDTH-1:0] rf_source,
    input  logic [WIDTH-1:0]        rf_rdata
);
    localparam int LW = ADDRESSWIDTH + 1;
    localparam logic [LW-1:0]           DEPTH_LEN = LW'(DEPTH);
    localparam logic [LW-1:0]           ONE_LEN   = LW'(1);
    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DEPTH - 1);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_ONE  = ADDRESSWIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;
    state_t r_state, w_state_next;

    logic                    r_req_ready, r_rsp_valid, r_rf_we;
    logic [ADDRESSWIDTH-1:0] r_rf_dest, r_rf_source, r_burst_addr;
    logic [WIDTH-1:0]        r_rf_wdata;
    logic [LW-1:0]           r_remain;
    logic                    r_s1_valid, r_s1_last, r_s2_valid, r_s2_last;
    logic [ADDRESSWIDTH-1:0] r_s2_addr;
    logic [2:0]              r_count;
    logic [WIDTH-1:0]        r_q_data [4];
    logic [ADDRESSWIDTH-1:0] r_q_addr [4];
    logic [3:0]              r_q_last;

    logic                    w_accept, w_accept_wr, w_accept_rd, w_issue;
    logic                    w_push, w_pop, w_ready_next;
    logic [LW-1:0]           w_len;
    logic [3:0]              w_occupancy;
    logic [2:0]              w_count_next, w_wr_idx;
    logic [ADDRESSWIDTH-1:0] w_req_addr_inc, w_burst_addr_inc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_len = req_len;
        if (req_len == '0) begin
            w_len = ONE_LEN;
        end else if (req_len > DEPTH_LEN) begin
            w_len = DEPTH_LEN;
        end
        w_accept    = r_req_ready && req_valid;
        w_accept_wr = w_accept && req_write;
        w_accept_rd = w_accept && !req_write;
        // Occupancy ignores a same-cycle pop, so the 4-entry FIFO can never be overrun.
        w_occupancy = {1'b0, r_count} + {3'b0, r_s1_valid} + {3'b0, r_s2_valid};
        w_issue     = (r_state == S_READ) && (w_occupancy < 4'd4);
        w_push      = r_s2_valid;
        w_pop       = r_rsp_valid && rsp_ready;
        w_count_next = r_count + {2'b0, w_push} - {2'b0, w_pop};
        w_wr_idx     = r_count - {2'b0, w_pop};
        w_req_addr_inc   = (req_addr == LAST_ADDR) ? '0 : req_addr + ADDR_ONE;
        w_burst_addr_inc = (r_burst_addr == LAST_ADDR) ? '0 : r_burst_addr + ADDR_ONE;

        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_wr) begin
                    w_state_next = S_WRITE;
                end else if (w_accept_rd) begin
                    // The first beat issues on the accept edge itself.
                    w_state_next = (w_len == ONE_LEN) ? S_DRAIN : S_READ;
                end
            end
            S_WRITE: w_state_next = S_IDLE;
            S_READ: begin
                if (w_issue && r_remain == ONE_LEN) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_s1_valid && !r_s2_valid && w_count_next == 3'd0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_ready_next = (w_state_next == S_IDLE) && (w_count_next == 3'd0)
                       && !w_accept_rd && !w_issue && !r_s1_valid;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_dest    <= '0;
            r_rf_wdata   <= '0;
            r_rf_source  <= '0;
            r_burst_addr <= '0;
            r_remain     <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_last    <= 1'b0;
            r_s2_addr    <= '0;
            r_count      <= '0;
            r_q_last     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q_data[i] <= '0;
                r_q_addr[i] <= '0;
            end
        end else begin
            r_req_ready <= w_ready_next;
            r_rf_we     <= w_accept_wr;
            if (w_accept_wr) begin
                r_rf_dest  <= req_addr;
                r_rf_wdata <= req_wdata;
            end
            r_s1_valid <= w_accept_rd || w_issue;
            if (w_accept_rd) begin
                r_rf_source  <= req_addr;
                r_s1_last    <= (w_len == ONE_LEN);
                r_burst_addr <= w_req_addr_inc;
                r_remain     <= w_len - ONE_LEN;
            end else if (w_issue) begin
                r_rf_source  <= r_burst_addr;
                r_s1_last    <= (r_remain == ONE_LEN);
                r_burst_addr <= w_burst_addr_inc;
                r_remain     <= r_remain - ONE_LEN;
            end
            r_s2_valid  <= r_s1_valid;
            r_s2_addr   <= r_rf_source;
            r_s2_last   <= r_s1_last;
            r_count     <= w_count_next;
            r_rsp_valid <= (w_count_next != 3'd0);
            // Shift-register FIFO: entry 0 is the registered response head.
            for (int i = 0; i < 3; i++) begin
                if (w_push && w_wr_idx == 3'(i)) begin
                    r_q_data[i] <= rf_rdata;
                    r_q_addr[i] <= r_s2_addr;
                    r_q_last[i] <= r_s2_last;
                end else if (w_pop) begin
                    if (3'(i + 1) < r_count) begin
                        r_q_data[i] <= r_q_data[i+1];
                        r_q_addr[i] <= r_q_addr[i+1];
                        r_q_last[i] <= r_q_last[i+1];
                    end else begin
                        r_q_data[i] <= '0;
                        r_q_addr[i] <= '0;
                        r_q_last[i] <= 1'b0;
                    end
                end
            end
            if (w_push && w_wr_idx == 3'd3) begin
                r_q_data[3] <= rf_rdata;
                r_q_addr[3] <= r_s2_addr;
                r_q_last[3] <= r_s2_last;
            end else if (w_pop) begin
                r_q_data[3] <= '0;
                r_q_addr[3] <= '0;
                r_q_last[3] <= 1'b0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_q_data[0];
    assign rsp_addr  = r_q_addr[0];
    assign rsp_last  = r_q_last[0];
    assign rf_we     = r_rf_we;
    assign rf_dest   = r_rf_dest;
    assign rf_wdata  = r_rf_wdata;
    assign rf_source = r_rf_source;
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb/tb_rf_access_ctrl.sv - randomized self-checking bench for rf_access_ctrl
module tb_rf_access_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [5:0]  req_len = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_last;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_addr;
    logic        rf_we;
    logic [4:0]  rf_dest, rf_source;
    logic [31:0] rf_wdata, rf_rdata;

    rf_access_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
        .rf_source(rf_source), .rf_rdata(rf_rdata)
    );

    always #5 clock = ~clock;

    // Register file: synchronous write, registered read, zeroed by reset.
    logic [31:0] rf_mem [32];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            rf_rdata <= '0;
        end else begin
            if (rf_we) rf_mem[rf_dest] <= rf_wdata;
            rf_rdata <= rf_mem[rf_source];
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        last;
        logic        first;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] shadow [32];
    int n_checks = 0, n_errors = 0;
    int cyc = 0, t_wr = -100, t_rd = -100, last_pop_cyc = 0, n_pops = 0;
    int ready_mode = 0;
    logic [4:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic        first_pending = 1'b0;
    logic        hold_pending = 1'b0, hold_last;
    logic [31:0] hold_data;
    logic [4:0]  hold_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Evaluate the handshakes of the coming edge, update the model, then advance one cycle.
    task automatic tick();
        beat_t e;
        int    len;
        if (reset && hold_pending) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, hold_data);
            check("hold_addr", rsp_addr, hold_addr);
            check("hold_last", rsp_last, hold_last);
        end
        hold_pending = reset && rsp_valid && !rsp_ready;
        hold_data = rsp_data;
        hold_addr = rsp_addr;
        hold_last = rsp_last;
        if (reset) begin
            check("rf_we", rf_we, (cyc == t_wr + 1));
            if (cyc == t_wr + 1) begin
                check("rf_dest", rf_dest, wr_addr);
                check("rf_wdata", rf_wdata, wr_data);
                check("ready_in_write", req_ready, 0);
            end
            if (cyc == t_rd + 1) check("rf_source_first", rf_source, rd_addr);
            if (first_pending && rsp_valid) begin
                check("rsp_latency", cyc - t_rd, 3);
                first_pending = 1'b0;
            end
            if (exp_q.size() != 0) check("ready_busy", req_ready, 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_addr", rsp_addr, e.addr);
                    check("rsp_last", rsp_last, e.last);
                    if (ready_mode == 0 && !e.first) check("stream_gap", cyc - last_pop_cyc, 1);
                end
                n_pops++;
                last_pop_cyc = cyc;
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    shadow[req_addr] = req_wdata;
                    t_wr = cyc;
                    wr_addr = req_addr;
                    wr_data = req_wdata;
                end else begin
                    len = (req_len == 0) ? 1 : ((req_len > 32) ? 32 : int'(req_len));
                    for (int j = 0; j < len; j++) begin
                        e.addr  = 5'((int'(req_addr) + j) % 32);
                        e.data  = shadow[e.addr];
                        e.last  = (j == len - 1);
                        e.first = (j == 0);
                        exp_q.push_back(e);
                    end
                    t_rd = cyc;
                    rd_addr = req_addr;
                    first_pending = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        case (ready_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = (cyc % 3 == 0);
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send(input logic wr, input logic [4:0] a, input logic [5:0] len, input logic [31:0] d);
        int n = 0;
        req_valid = 1'b0;
        while (!req_ready && n < 400) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
        end else begin
            req_valid = 1'b1;
            req_write = wr;
            req_addr  = a;
            req_len   = len;
            req_wdata = d;
            tick();
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 1000) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rf_we", rf_we, 0);
            check("rst_req_ready", req_ready, 0);
        end
        exp_q.delete();
        first_pending = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        reset = 1'b1;
        tick();
        check("ready_after_release", req_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        apply_reset(3);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_rf_dest", rf_dest, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_rf_source", rf_source, 0);

        ready_mode = 0;
        send(1'b1, 5'd5, 6'd0, 32'hDEADBEEF);
        send(1'b0, 5'd5, 6'd1, 32'h0);
        wait_idle();

        for (int k = 0; k < 32; k++) send(1'b1, 5'(k), 6'd0, 32'(k + 'h100));
        p0 = n_pops;
        send(1'b0, 5'd30, 6'd4, 32'h0);
        wait_idle();
        check("wrap_beats", n_pops - p0, 4);

        ready_mode = 1;
        p0 = n_pops;
        send(1'b0, 5'd0, 6'd32, 32'h0);
        wait_idle();
        check("bp_beats", n_pops - p0, 32);

        ready_mode = 0;
        p0 = n_pops;
        send(1'b0, 5'd7, 6'd0, 32'h0);
        wait_idle();
        check("len0_beats", n_pops - p0, 1);
        p0 = n_pops;
        send(1'b0, 5'd0, 6'd40, 32'h0);
        wait_idle();
        check("len40_beats", n_pops - p0, 32);

        p0 = n_pops;
        send(1'b0, 5'd0, 6'd16, 32'h0);
        for (int n = 0; n < 100 && (n_pops - p0) < 3; n++) tick();
        apply_reset(3);
        send(1'b1, 5'd2, 6'd0, 32'hCAFE0002);
        send(1'b0, 5'd2, 6'd1, 32'h0);
        wait_idle();

        ready_mode = 2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                send(1'b1, 5'($urandom_range(0, 31)), 6'd0, $urandom);
            else
                send(1'b0, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 32'h0);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
